// File: rtl/reg_pipe.sv
// reg_pipe: valid/ready register pipeline of DEPTH stages; optional occupancy count via `REG_PIPE_COUNT_EN.
// Latency DEPTH cycles; under backpressure bubbles collapse and in_ready is combinational from out_ready.
module reg_pipe #(
  parameter int               WIDTH   = 4,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush
`ifdef REG_PIPE_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_nxt;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] r;
  logic [DEPTH-1:0] ld;
  logic             accept;
  logic             all_full;

  // A stage is ready when downstream drains or any stage from here to the output is empty.
  always_comb begin
    r        = '0;
    all_full = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      all_full = all_full & v[i];
      r[i]     = out_ready | ~all_full;
    end
  end

  assign in_ready = r[0] & ~flush;
  assign accept   = in_valid & in_ready;

  always_comb begin
    v_nxt = v;
    ld    = '0;
    if (flush) begin
      v_nxt = '0;
    end else begin
      if (r[0]) v_nxt[0] = accept;
      ld[0] = accept;
      for (int i = 1; i < DEPTH; i++) begin
        if (r[i]) v_nxt[i] = v[i-1];
        ld[i] = r[i] & v[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) v <= '0;
    else     v <= v_nxt;
  end

  // Data registers only load when a real word is written into them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) d[i] <= RST_VAL;
    end else begin
      if (ld[0]) d[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        if (ld[i]) d[i] <= d[i-1];
      end
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

`ifdef REG_PIPE_COUNT_EN
  localparam int CW = $clog2(DEPTH + 1);
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + CW'(v_nxt[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else     count <= cnt_nxt;
  end
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// Directed bench for reg_pipe (WIDTH=4, DEPTH=3, RST_VAL=0); inputs driven and outputs sampled on the falling edge.
module tb_reg_pipe;
  localparam int WIDTH = 4;
  localparam int DEPTH = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
`ifdef REG_PIPE_COUNT_EN
  logic [1:0]       count;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(4'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush)
`ifdef REG_PIPE_COUNT_EN
    ,
    .count     (count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic chk_count(input string tag, input logic [31:0] exp);
`ifdef REG_PIPE_COUNT_EN
    chk(tag, 32'(count), exp);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // reset, with a word offered that must not be taken
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 4'hF;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data),  0);
    chk("rst_in_ready",  32'(in_ready),  1);
    chk_count("rst_count", 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_no_accept", 32'(out_valid), 0);
    rst = 1'b0; in_valid = 1'b0;
    tick(); tick(); tick();
    chk("post_rst_empty", 32'(out_valid), 0);

    // streaming at full rate
    out_ready = 1'b1; in_valid = 1'b1; in_data = 4'hA; tick();
    in_data = 4'hB; tick();
    in_data = 4'hC; tick();
    chk("stream_v_e3", 32'(out_valid), 1);
    chk("stream_d_e3", 32'(out_data),  32'hA);
    chk_count("stream_count", 3);
    in_valid = 1'b0; tick();
    chk("stream_d_e4", 32'(out_data),  32'hB);
    tick();
    chk("stream_d_e5", 32'(out_data),  32'hC);
    chk("stream_v_e5", 32'(out_valid), 1);
    tick();
    chk("stream_drained", 32'(out_valid), 0);

    // backpressure, then simultaneous emit/accept on a full pipe
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h1; tick();
    in_data = 4'h2; tick();
    in_data = 4'h3; tick();
    in_data = 4'h4;
    #1;
    chk("bp_in_ready_full", 32'(in_ready), 0);
    chk("bp_out_data",      32'(out_data), 32'h1);
    chk_count("bp_count", 3);
    tick();
    chk("bp_hold_data",  32'(out_data),  32'h1);
    chk("bp_hold_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_drain", 32'(in_ready), 1);
    tick();
    chk("bp_swap_data", 32'(out_data), 32'h2);
    chk_count("bp_swap_count", 3);
    in_valid = 1'b0; tick();
    chk("bp_d3", 32'(out_data), 32'h3);
    tick();
    chk("bp_d4", 32'(out_data), 32'h4);
    tick();
    chk("bp_drained", 32'(out_valid), 0);

    // bubble collapse behind a stalled output
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h5; tick();
    in_valid = 1'b0;
    chk("bub_not_yet", 32'(out_valid), 0);
    tick(); tick();
    chk("bub_5_valid", 32'(out_valid), 1);
    chk("bub_5_data",  32'(out_data),  32'h5);
    in_valid = 1'b1; in_data = 4'h6;
    #1;
    chk("bub_in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0; tick();
    chk("bub_in_ready_s1", 32'(in_ready), 1);
    chk("bub_hold_5",      32'(out_data), 32'h5);
    chk_count("bub_count", 2);
    out_ready = 1'b1; tick();
    chk("bub_6_data",  32'(out_data),  32'h6);
    chk("bub_6_valid", 32'(out_valid), 1);
    tick();
    chk("bub_drained", 32'(out_valid), 0);

    // flush with words held and a word offered
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h7; tick();
    in_data = 4'h8; tick();
    in_data = 4'h9; flush = 1'b1;
    #1;
    chk("fl_in_ready", 32'(in_ready), 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 32'(out_valid), 0);
    chk("fl_data_kept", 32'(out_data),  32'h6);
    chk_count("fl_count", 0);
    out_ready = 1'b1; tick(); tick(); tick();
    chk("fl_dropped", 32'(out_valid), 0);

    // asynchronous reset while full
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'hA; tick();
    in_data = 4'hB; tick();
    in_data = 4'hC; tick();
    in_valid = 1'b0;
    chk("mid_full_valid", 32'(out_valid), 1);
    chk("mid_full_data",  32'(out_data),  32'hA);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data",  32'(out_data),  0);
    chk_count("mid_rst_count", 0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    tick();
    chk("mid_rst_empty", 32'(out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
